// File: rtl/lsu_data_access.sv
// Memory-stage load/store unit: turns the MEM-stage effective address into one
// or two aligned req/gnt/rvalid bus beats and returns extended load data.
`timescale 1ns/1ps
module lsu_data_access #(
  parameter int unsigned       XLEN             = 64,
  parameter int unsigned       ADDR_W           = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR       = ADDR_W'(32'h8000_0000),
  parameter bit                SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [XLEN-1:0]   store_data,
  input  logic              flush_mem,
  input  logic              cancel_instr_mem,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              mem_stall,
  output logic [XLEN-1:0]   load_data,
  output logic              load_valid,
  output logic              store_done,
  output logic              misalign_exc
);

  localparam int unsigned W    = XLEN / 8;
  localparam int unsigned OFFW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE, S_DRAIN
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic [OFFW-1:0]   off_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              uns_q;
  logic              cross_q;
  logic [XLEN-1:0]   sdata_q;
  logic [XLEN-1:0]   beat0_q;
  logic [XLEN-1:0]   beat1_q;

  logic              kill;
  logic              accept;
  logic [OFFW-1:0]   off_in;
  logic [3:0]        n_in;
  logic              cross_in;
  logic              exc_in;

  // Accept-time decode of the incoming access
  assign kill     = flush_mem | cancel_instr_mem;
  assign accept   = (state == S_IDLE) && mem_valid && !kill;
  assign off_in   = alu_res[OFFW-1:0];
  assign n_in     = 4'd1 << mem_size;
  assign cross_in = (5'(off_in) + 5'(n_in)) > 5'(W);
  assign exc_in   = ((mem_size == 2'd3) && (XLEN == 32)) ||
                    (!SPLIT_MISALIGNED && ((4'(off_in) & (n_in - 4'd1)) != 4'd0));

  // Lane placement: beat 0 takes the low half, beat 1 the spill-over
  logic [7:0]          mask8;
  logic [2*W-1:0]      strb2;
  logic [2*XLEN-1:0]   wdata2;
  logic [ADDR_W-1:0]   base_addr;
  logic                in_req;
  logic                second;

  always_comb begin
    mask8 = 8'h01;
    unique case (size_q)
      2'd0: mask8 = 8'h01;
      2'd1: mask8 = 8'h03;
      2'd2: mask8 = 8'h0F;
      2'd3: mask8 = 8'hFF;
    endcase
  end

  assign strb2     = {{W{1'b0}}, W'(mask8)} << off_q;
  assign wdata2    = {{XLEN{1'b0}}, sdata_q} << {off_q, 3'b000};
  assign base_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign in_req    = (state == S_REQ0) || (state == S_REQ1);
  assign second    = (state == S_REQ1) || (state == S_WAIT1);

  // A request may be withdrawn on flush unless it is granted the same cycle
  assign bus_req   = in_req && !(kill && !bus_gnt);
  assign bus_we    = bus_req && we_q;
  assign mem_stall = accept ||
                     (state inside {S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DRAIN});

  always_comb begin
    bus_addr  = RESET_ADDR;
    bus_wdata = '0;
    bus_wstrb = '0;
    if (state inside {S_REQ0, S_WAIT0}) begin
      bus_addr = base_addr;
    end else if (second) begin
      bus_addr = base_addr + ADDR_W'(W);
    end
    if (bus_req && we_q) begin
      bus_wdata = second ? wdata2[2*XLEN-1:XLEN] : wdata2[XLEN-1:0];
      bus_wstrb = second ? strb2[2*W-1:W] : strb2[W-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = exc_in ? S_DONE : S_REQ0;
        end
      end
      S_REQ0: begin
        if (kill) begin
          state_n = bus_gnt ? S_DRAIN : S_IDLE;
        end else if (bus_gnt) begin
          state_n = S_WAIT0;
        end
      end
      S_WAIT0: begin
        if (kill) begin
          state_n = bus_rvalid ? S_IDLE : S_DRAIN;
        end else if (bus_rvalid) begin
          state_n = cross_q ? S_REQ1 : S_DONE;
        end
      end
      S_REQ1: begin
        if (kill) begin
          state_n = bus_gnt ? S_DRAIN : S_IDLE;
        end else if (bus_gnt) begin
          state_n = S_WAIT1;
        end
      end
      S_WAIT1: begin
        if (kill) begin
          state_n = bus_rvalid ? S_IDLE : S_DRAIN;
        end else if (bus_rvalid) begin
          state_n = S_DONE;
        end
      end
      S_DONE: state_n = S_IDLE;
      S_DRAIN: begin
        if (bus_rvalid) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Load assembly: the completing beat is taken straight from the bus
  logic [XLEN-1:0]   asm_b0;
  logic [XLEN-1:0]   asm_b1;
  logic [2*XLEN-1:0] asm_sh;
  logic [XLEN-1:0]   asm_v;
  logic              asm_sgn;
  int unsigned       asm_bits;
  logic [XLEN-1:0]   load_asm;

  assign asm_b0 = (state == S_WAIT0) ? bus_rdata : beat0_q;
  assign asm_b1 = (state == S_WAIT1) ? bus_rdata : beat1_q;
  assign asm_sh = {asm_b1, asm_b0} >> {off_q, 3'b000};
  assign asm_v  = asm_sh[XLEN-1:0];

  always_comb begin
    asm_sgn  = asm_v[7];
    asm_bits = 8;
    unique case (size_q)
      2'd0: begin asm_sgn = asm_v[7];      asm_bits = 8;    end
      2'd1: begin asm_sgn = asm_v[15];     asm_bits = 16;   end
      2'd2: begin asm_sgn = asm_v[31];     asm_bits = 32;   end
      2'd3: begin asm_sgn = asm_v[XLEN-1]; asm_bits = XLEN; end
    endcase
    load_asm = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      load_asm[i] = (i < asm_bits) ? asm_v[i] : (asm_sgn & !uns_q);
    end
  end

  // Access latch, beat buffers and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      off_q        <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      cross_q      <= 1'b0;
      sdata_q      <= '0;
      beat0_q      <= '0;
      beat1_q      <= '0;
      load_data    <= '0;
      load_valid   <= 1'b0;
      store_done   <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      load_valid   <= 1'b0;
      store_done   <= 1'b0;
      misalign_exc <= 1'b0;
      if (accept) begin
        addr_q  <= alu_res[ADDR_W-1:0];
        off_q   <= off_in;
        size_q  <= mem_size;
        we_q    <= mem_we;
        uns_q   <= mem_unsigned;
        cross_q <= cross_in;
        sdata_q <= store_data;
        beat0_q <= '0;
        beat1_q <= '0;
      end
      if ((state == S_WAIT0) && bus_rvalid) begin
        beat0_q <= bus_rdata;
      end
      if ((state == S_WAIT1) && bus_rvalid) begin
        beat1_q <= bus_rdata;
      end
      if ((state_n == S_DONE) && (state != S_DONE)) begin
        if (state == S_IDLE) begin
          misalign_exc <= 1'b1;
        end else if (we_q) begin
          store_done <= 1'b1;
        end else begin
          load_valid <= 1'b1;
          load_data  <= load_asm;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_data_access.sv
// Directed bench for lsu_data_access: single/split loads and stores,
// misalign exception, flush/cancel handling and asynchronous reset.
`timescale 1ns/1ps
module tb_lsu_data_access;

  localparam logic [31:0] RST_ADDR = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_valid_ns, mem_we, mem_unsigned;
  logic [1:0]  mem_size;
  logic [63:0] alu_res, store_data, bus_rdata;
  logic        flush_mem, cancel_instr_mem, bus_gnt, bus_rvalid;

  logic        bus_req, bus_we, mem_stall, load_valid, store_done, misalign_exc;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata, load_data;
  logic [7:0]  bus_wstrb;

  logic        bus_req_ns, bus_we_ns, mem_stall_ns, load_valid_ns, store_done_ns, misalign_exc_ns;
  logic [31:0] bus_addr_ns;
  logic [63:0] bus_wdata_ns, load_data_ns;
  logic [7:0]  bus_wstrb_ns;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lsu_data_access #(.XLEN(64), .ADDR_W(32), .RESET_ADDR(32'h8000_0000), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .alu_res(alu_res), .store_data(store_data),
    .flush_mem(flush_mem), .cancel_instr_mem(cancel_instr_mem),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .store_done(store_done), .misalign_exc(misalign_exc)
  );

  lsu_data_access #(.XLEN(64), .ADDR_W(32), .RESET_ADDR(32'h8000_0000), .SPLIT_MISALIGNED(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid_ns), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .alu_res(alu_res), .store_data(store_data),
    .flush_mem(flush_mem), .cancel_instr_mem(cancel_instr_mem),
    .bus_req(bus_req_ns), .bus_gnt(bus_gnt), .bus_we(bus_we_ns), .bus_addr(bus_addr_ns),
    .bus_wdata(bus_wdata_ns), .bus_wstrb(bus_wstrb_ns), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall_ns), .load_data(load_data_ns), .load_valid(load_valid_ns),
    .store_done(store_done_ns), .misalign_exc(misalign_exc_ns)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic present(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] sdata);
    mem_valid    = 1'b1;
    mem_we       = we;
    mem_size     = size;
    mem_unsigned = uns;
    alu_res      = addr;
    store_data   = sdata;
  endtask

  // One aligned beat, granted at once, response one cycle later
  task automatic do_single(input logic we, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] rdata,
                           output logic [31:0] o_addr, output logic [7:0] o_strb,
                           output logic [63:0] o_wdata, output logic o_we,
                           output logic o_lv, output logic o_sd, output logic [63:0] o_ld);
    present(we, size, uns, addr, sdata);
    step();
    mem_valid = 1'b0;
    bus_gnt   = 1'b1;
    settle();
    o_addr  = bus_addr;
    o_strb  = bus_wstrb;
    o_wdata = bus_wdata;
    o_we    = bus_we;
    step();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = rdata;
    step();
    bus_rvalid = 1'b0;
    settle();
    o_lv = load_valid;
    o_sd = store_done;
    o_ld = load_data;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_valid = 0; mem_valid_ns = 0; mem_we = 0; mem_size = 0; mem_unsigned = 0;
    alu_res = '0; store_data = '0; flush_mem = 0; cancel_instr_mem = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
    step(); step();
    n_checks++; if (bus_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", bus_req); else n_pass++;
    n_checks++; if (bus_addr !== RST_ADDR) $display("FAIL rst_addr: got %h want %h", bus_addr, RST_ADDR); else n_pass++;
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL rst_stall: got %0b want 0", mem_stall); else n_pass++;
    n_checks++; if ({load_valid, store_done, misalign_exc} !== 3'b000)
      $display("FAIL rst_pulses: got %b want 000", {load_valid, store_done, misalign_exc}); else n_pass++;
    n_checks++; if (load_data !== 64'h0) $display("FAIL rst_load_data: got %h want 0", load_data); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lw();
    present(1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'h0);
    settle();
    n_checks++; if (mem_stall !== 1'b1) $display("FAIL lw_stall_c0: got %0b want 1", mem_stall); else n_pass++;
    step();
    mem_valid = 1'b0;
    settle();
    n_checks++; if (bus_req !== 1'b1) $display("FAIL lw_req_c1: got %0b want 1", bus_req); else n_pass++;
    n_checks++; if (bus_addr !== 32'h8000_0010) $display("FAIL lw_addr: got %h want 80000010", bus_addr); else n_pass++;
    n_checks++; if (bus_wstrb !== 8'h00 || bus_we !== 1'b0)
      $display("FAIL lw_strb_we: got %h/%0b want 00/0", bus_wstrb, bus_we); else n_pass++;
    step();
    bus_gnt = 1'b1;
    settle();
    n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h8000_0010)
      $display("FAIL lw_hold_c2: got %0b/%h want 1/80000010", bus_req, bus_addr); else n_pass++;
    step();
    bus_gnt = 1'b0;
    settle();
    n_checks++; if (bus_req !== 1'b0 || mem_stall !== 1'b1)
      $display("FAIL lw_wait_c3: req/stall got %0b/%0b want 0/1", bus_req, mem_stall); else n_pass++;
    step();
    bus_rvalid = 1'b1;
    bus_rdata  = 64'h0000_0000_F000_0001;
    settle();
    n_checks++; if (mem_stall !== 1'b1) $display("FAIL lw_stall_c4: got %0b want 1", mem_stall); else n_pass++;
    step();
    bus_rvalid = 1'b0;
    settle();
    n_checks++; if (load_valid !== 1'b1) $display("FAIL lw_valid_c5: got %0b want 1", load_valid); else n_pass++;
    n_checks++; if (load_data !== 64'hFFFF_FFFF_F000_0001)
      $display("FAIL lw_data: got %h want ffffffff_f0000001", load_data); else n_pass++;
    n_checks++; if (mem_stall !== 1'b0 || bus_addr !== RST_ADDR)
      $display("FAIL lw_done_c5: stall/addr got %0b/%h want 0/%h", mem_stall, bus_addr, RST_ADDR); else n_pass++;
    step();
    n_checks++; if (load_valid !== 1'b0) $display("FAIL lw_valid_c6: got %0b want 0", load_valid); else n_pass++;
  endtask

  task automatic test_ld_split();
    present(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0);
    step();
    mem_valid = 1'b0;
    bus_gnt   = 1'b1;
    settle();
    n_checks++; if (bus_addr !== 32'h8000_0000) $display("FAIL ld_b0_addr: got %h want 80000000", bus_addr); else n_pass++;
    step();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 64'h1122_3344_DEAD_BEEF;
    step();
    bus_rvalid = 1'b0;
    bus_gnt    = 1'b1;
    settle();
    n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h8000_0008)
      $display("FAIL ld_b1_req: got %0b/%h want 1/80000008", bus_req, bus_addr); else n_pass++;
    step();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 64'hCAFE_F00D_5566_7788;
    step();
    bus_rvalid = 1'b0;
    settle();
    n_checks++; if (load_valid !== 1'b1 || load_data !== 64'h5566_7788_1122_3344)
      $display("FAIL ld_split_data: got %0b/%h want 1/5566778811223344", load_valid, load_data); else n_pass++;
    step();
  endtask

  task automatic test_sh_split();
    present(1'b1, 2'd1, 1'b0, 64'h8000_0007, 64'h0000_0000_0000_ABCD);
    step();
    mem_valid = 1'b0;
    settle();
    n_checks++; if (bus_wstrb !== 8'h80 || bus_wdata !== 64'hCD00_0000_0000_0000 || bus_we !== 1'b1)
      $display("FAIL sh_b0: strb/wdata/we got %h/%h/%0b want 80/cd000000_00000000/1", bus_wstrb, bus_wdata, bus_we); else n_pass++;
    step();
    bus_gnt = 1'b1;
    settle();
    n_checks++; if (bus_addr !== 32'h8000_0000 || bus_wstrb !== 8'h80)
      $display("FAIL sh_b0_hold: addr/strb got %h/%h want 80000000/80", bus_addr, bus_wstrb); else n_pass++;
    step();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    bus_gnt    = 1'b1;
    settle();
    n_checks++; if (bus_addr !== 32'h8000_0008 || bus_wstrb !== 8'h01 || bus_wdata !== 64'h0000_0000_0000_00AB)
      $display("FAIL sh_b1: addr/strb/wdata got %h/%h/%h want 80000008/01/ab", bus_addr, bus_wstrb, bus_wdata); else n_pass++;
    step();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    settle();
    n_checks++; if (store_done !== 1'b1 || load_valid !== 1'b0)
      $display("FAIL sh_done: store_done/load_valid got %0b/%0b want 1/0", store_done, load_valid); else n_pass++;
    step();
    n_checks++; if (store_done !== 1'b0) $display("FAIL sh_done_once: got %0b want 0", store_done); else n_pass++;
  endtask

  task automatic test_sw_aligned();
    logic [31:0] a; logic [7:0] s; logic [63:0] wd, ld; logic w, lv, sd;
    do_single(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h1111_2222_DEAD_BEEF, 64'h0, a, s, wd, w, lv, sd, ld);
    n_checks++; if (a !== 32'h8000_0000 || s !== 8'hF0 || w !== 1'b1)
      $display("FAIL sw_beat: addr/strb/we got %h/%h/%0b want 80000000/f0/1", a, s, w); else n_pass++;
    n_checks++; if (wd !== 64'hDEAD_BEEF_0000_0000) $display("FAIL sw_wdata: got %h want deadbeef_00000000", wd); else n_pass++;
    n_checks++; if (sd !== 1'b1 || lv !== 1'b0) $display("FAIL sw_pulse: sd/lv got %0b/%0b want 1/0", sd, lv); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a; logic [7:0] s; logic [63:0] wd, ld; logic w, lv, sd;
    do_single(1'b0, 2'd0, 1'b1, 64'h8000_0013, 64'h0, 64'h0102_0304_8506_0708, a, s, wd, w, lv, sd, ld);
    n_checks++; if (a !== 32'h8000_0010 || s !== 8'h00) $display("FAIL lbu_beat: addr/strb got %h/%h want 80000010/00", a, s); else n_pass++;
    n_checks++; if (lv !== 1'b1 || ld !== 64'h85) $display("FAIL lbu_data: got %0b/%h want 1/85", lv, ld); else n_pass++;
    do_single(1'b0, 2'd0, 1'b0, 64'h8000_0013, 64'h0, 64'h0102_0304_8506_0708, a, s, wd, w, lv, sd, ld);
    n_checks++; if (lv !== 1'b1 || ld !== 64'hFFFF_FFFF_FFFF_FF85)
      $display("FAIL lb_data: got %0b/%h want 1/ffffffffffffff85", lv, ld); else n_pass++;
    do_single(1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, a, s, wd, w, lv, sd, ld);
    n_checks++; if (a !== 32'h8000_0000 || ld !== 64'hFFFF_FFFF_FFFF_8001)
      $display("FAIL lh_data: addr/data got %h/%h want 80000000/ffffffffffff8001", a, ld); else n_pass++;
    do_single(1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, a, s, wd, w, lv, sd, ld);
    n_checks++; if (ld !== 64'h0000_0000_0000_8001) $display("FAIL lhu_data: got %h want 8001", ld); else n_pass++;
  endtask

  task automatic test_no_split();
    mem_valid_ns = 1'b1;
    mem_we = 1'b0; mem_size = 2'd1; mem_unsigned = 1'b0; alu_res = 64'h8000_0003;
    settle();
    n_checks++; if (bus_req_ns !== 1'b0 || mem_stall_ns !== 1'b1)
      $display("FAIL ns_c0: req/stall got %0b/%0b want 0/1", bus_req_ns, mem_stall_ns); else n_pass++;
    step();
    mem_valid_ns = 1'b0;
    settle();
    n_checks++; if (misalign_exc_ns !== 1'b1 || load_valid_ns !== 1'b0 || store_done_ns !== 1'b0)
      $display("FAIL ns_exc: exc/lv/sd got %0b/%0b/%0b want 1/0/0", misalign_exc_ns, load_valid_ns, store_done_ns); else n_pass++;
    n_checks++; if (bus_req_ns !== 1'b0 || bus_we_ns !== 1'b0 || bus_addr_ns !== RST_ADDR || mem_stall_ns !== 1'b0)
      $display("FAIL ns_bus: req/we/addr/stall got %0b/%0b/%h/%0b want 0/0/%h/0", bus_req_ns, bus_we_ns, bus_addr_ns, mem_stall_ns, RST_ADDR); else n_pass++;
    step();
    n_checks++; if (misalign_exc_ns !== 1'b0 || load_valid_ns !== 1'b0 || bus_req_ns !== 1'b0)
      $display("FAIL ns_after: exc/lv/req got %0b/%0b/%0b want 0/0/0", misalign_exc_ns, load_valid_ns, bus_req_ns); else n_pass++;
    n_checks++; if (bus_wdata_ns !== 64'h0 || bus_wstrb_ns !== 8'h0 || load_data_ns !== 64'h0)
      $display("FAIL ns_idle_vals: wdata/strb/ld got %h/%h/%h want 0/0/0", bus_wdata_ns, bus_wstrb_ns, load_data_ns); else n_pass++;
  endtask

  task automatic test_flush_req0();
    present(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'h0123_4567_89AB_CDEF);
    step();
    mem_valid = 1'b0;
    settle();
    n_checks++; if (bus_req !== 1'b1 || bus_wstrb !== 8'hFF)
      $display("FAIL fl0_req: req/strb got %0b/%h want 1/ff", bus_req, bus_wstrb); else n_pass++;
    step();
    flush_mem = 1'b1;
    settle();
    n_checks++; if (bus_req !== 1'b0 || bus_wstrb !== 8'h00 || bus_wdata !== 64'h0)
      $display("FAIL fl0_drop: req/strb/wdata got %0b/%h/%h want 0/00/0", bus_req, bus_wstrb, bus_wdata); else n_pass++;
    step();
    flush_mem = 1'b0;
    settle();
    n_checks++; if (bus_req !== 1'b0 || mem_stall !== 1'b0 || bus_addr !== RST_ADDR)
      $display("FAIL fl0_idle: req/stall/addr got %0b/%0b/%h want 0/0/%h", bus_req, mem_stall, bus_addr, RST_ADDR); else n_pass++;
    step();
    n_checks++; if (store_done !== 1'b0 || load_valid !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL fl0_nopulse: sd/lv/req got %0b/%0b/%0b want 0/0/0", store_done, load_valid, bus_req); else n_pass++;
  endtask

  task automatic test_flush_wait0();
    present(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0);
    step();
    mem_valid = 1'b0;
    bus_gnt   = 1'b1;
    step();
    bus_gnt   = 1'b0;
    flush_mem = 1'b1;
    step();
    flush_mem = 1'b0;
    settle();
    n_checks++; if (mem_stall !== 1'b1 || bus_req !== 1'b0 || bus_addr !== RST_ADDR)
      $display("FAIL flw_drain: stall/req/addr got %0b/%0b/%h want 1/0/%h", mem_stall, bus_req, bus_addr, RST_ADDR); else n_pass++;
    bus_rvalid = 1'b1;
    bus_rdata  = 64'h1122_3344_5566_7788;
    step();
    bus_rvalid = 1'b0;
    settle();
    n_checks++; if (mem_stall !== 1'b0 || bus_req !== 1'b0 || load_valid !== 1'b0)
      $display("FAIL flw_idle: stall/req/lv got %0b/%0b/%0b want 0/0/0", mem_stall, bus_req, load_valid); else n_pass++;
    step();
    n_checks++; if (bus_req !== 1'b0 || load_valid !== 1'b0)
      $display("FAIL flw_nobeat1: req/lv got %0b/%0b want 0/0", bus_req, load_valid); else n_pass++;
  endtask

  task automatic test_cancel_gnt();
    present(1'b1, 2'd2, 1'b0, 64'h8000_0008, 64'h0000_0000_0000_1234);
    step();
    mem_valid        = 1'b0;
    cancel_instr_mem = 1'b1;
    bus_gnt          = 1'b1;
    settle();
    n_checks++; if (bus_req !== 1'b1 || bus_wstrb !== 8'h0F)
      $display("FAIL cg_granted: req/strb got %0b/%h want 1/0f", bus_req, bus_wstrb); else n_pass++;
    step();
    cancel_instr_mem = 1'b0;
    bus_gnt          = 1'b0;
    settle();
    n_checks++; if (mem_stall !== 1'b1 || bus_req !== 1'b0)
      $display("FAIL cg_drain: stall/req got %0b/%0b want 1/0", mem_stall, bus_req); else n_pass++;
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    settle();
    n_checks++; if (mem_stall !== 1'b0 || store_done !== 1'b0)
      $display("FAIL cg_idle: stall/sd got %0b/%0b want 0/0", mem_stall, store_done); else n_pass++;
    step();
    n_checks++; if (store_done !== 1'b0) $display("FAIL cg_nopulse: got %0b want 0", store_done); else n_pass++;
  endtask

  task automatic test_reset_async();
    present(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0);
    step();
    mem_valid = 1'b0;
    bus_gnt   = 1'b1;
    step();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    bus_rvalid = 1'b0;
    bus_gnt    = 1'b1;
    step();
    bus_gnt = 1'b0;
    settle();
    n_checks++; if (mem_stall !== 1'b1) $display("FAIL ra_wait1: stall got %0b want 1", mem_stall); else n_pass++;
    rst_n = 1'b0;
    settle();
    n_checks++; if (bus_addr !== RST_ADDR || mem_stall !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL ra_async: addr/stall/req got %h/%0b/%0b want %h/0/0", bus_addr, mem_stall, bus_req, RST_ADDR); else n_pass++;
    n_checks++; if (load_data !== 64'h0 || load_valid !== 1'b0)
      $display("FAIL ra_outs: ld/lv got %h/%0b want 0/0", load_data, load_valid); else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    bus_rvalid = 1'b1;
    bus_rdata  = 64'h1234_5678_9ABC_DEF0;
    step();
    bus_rvalid = 1'b0;
    settle();
    n_checks++; if (load_valid !== 1'b0 || mem_stall !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL ra_ignore: lv/stall/req got %0b/%0b/%0b want 0/0/0", load_valid, mem_stall, bus_req); else n_pass++;
    step();
    n_checks++; if (load_valid !== 1'b0 || load_data !== 64'h0)
      $display("FAIL ra_after: lv/ld got %0b/%h want 0/0", load_valid, load_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_ld_split();
    test_sh_split();
    test_sw_aligned();
    test_back_to_back();
    test_no_split();
    test_flush_req0();
    test_flush_wait0();
    test_cancel_gnt();
    test_reset_async();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_data_access.md
Name: lsu_data_access

Overview:
- Memory-stage load/store access unit for the core. Turns the MEM-stage ALU result into a data-bus transaction.
- Issues byte strobes and shifted store data over a req/gnt/rvalid bus.
- Handles misaligned accesses by splitting them into two aligned beats, or by raising an exception.
- Returns sign/zero-extended load data and stalls the pipeline while a transaction is outstanding.

Parameters:
- XLEN, 64, data path width; 32 or 64. W = XLEN/8, OFFW = log2(W).
- ADDR_W, 32, bus address width.
- RESET_ADDR, 32'h8000_0000, value driven on bus_addr when no transaction is active.
- SPLIT_MISALIGNED, 1. 1: word-crossing accesses are split into two beats. 0: any access not naturally aligned raises misalign_exc.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  load/store instruction present in MEM
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
- mem_unsigned  in  1  zero-extend load result
- alu_res  in  XLEN  effective address; low ADDR_W bits are used
- store_data  in  XLEN  rs2 value, right-aligned
- flush_mem  in  1  pipeline flush of MEM
- cancel_instr_mem  in  1  MEM instruction cancelled
- bus_req  out  1  request valid
- bus_gnt  in  1  request accepted this cycle
- bus_we  out  1  write request
- bus_addr  out  ADDR_W  W-aligned beat address
- bus_wdata  out  XLEN  lane-shifted store data
- bus_wstrb  out  W  byte enables
- bus_rvalid  in  1  response (read data or write ack) for oldest granted beat
- bus_rdata  in  XLEN  read data
- mem_stall  out  1  hold IF..MEM
- load_data  out  XLEN  extended load result
- load_valid  out  1  one-cycle pulse: load_data valid
- store_done  out  1  one-cycle pulse: store completed
- misalign_exc  out  1  one-cycle pulse: misaligned/illegal access

Behaviour:
- Reset (rst_n=0, async) state = IDLE. All outputs 0, except bus_addr = RESET_ADDR. Beat buffers cleared.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, DRAIN.
- accept = IDLE && mem_valid && !flush_mem && !cancel_instr_mem.
- On accept, latch the following:
  - addr
  - off = addr[OFFW-1:0]
  - n = 1<<mem_size
  - we, unsigned flag
  - store_data
  - cross = (off + n > W)
- Exception on accept: misalign_exc pulses the next cycle (state DONE, no bus traffic) when any of these holds:
  - mem_size = 3 with XLEN = 32
  - SPLIT_MISALIGNED = 0 and (off mod n) ≠ 0
- Otherwise the unit enters REQ0.
- Beat 0 encoding:
  - bus_addr = {addr[ADDR_W-1:OFFW], OFFW'b0}
  - bus_wstrb = (mask_n << off) truncated to W
  - bus_wdata = store_data << 8·off
- Beat 1 encoding (cross only):
  - bus_addr = beat-0 address + W
  - bus_wstrb = mask_n >> (W − off)
  - bus_wdata = store_data >> (XLEN − 8·off)
- REQ0/REQ1: bus_req = 1. addr, wdata, wstrb and we are held stable until bus_gnt. On gnt, go to WAIT0/WAIT1 (bus_req drops the next cycle).
- WAIT0: on rvalid, capture bus_rdata into beat0, then go to REQ1 if cross, else DONE.
- WAIT1: on rvalid, capture bus_rdata into beat1, then go to DONE.
- Load assembly (registered, visible in DONE):
  - v = ({beat1, beat0} >> 8·off)[8n−1:0]
  - load_data = sign- or zero-extended v
  - beat1 = 0 when not cross
- DONE:
  - load pulses load_valid; store pulses store_done; exception pulses misalign_exc
  - exactly one of the three pulses, for 1 cycle
  - return to IDLE
- mem_stall = accept || state ∈ {REQ0, WAIT0, REQ1, WAIT1, DRAIN}. It is low in DONE so the pipeline advances on the pulse cycle.
- Flush/cancel while in REQ0/REQ1 before gnt: bus_req drops that cycle (withdrawal is legal on this bus). Go to IDLE with no pulse.
- Flush/cancel in the same cycle as gnt, or in WAIT*: go to DRAIN. DRAIN absorbs the outstanding rvalid, issues no further beat and no pulse, then goes to IDLE. Note: a store beat already granted is committed.
- rvalid outside WAIT*/DRAIN is ignored.
- bus_addr = RESET_ADDR in IDLE, DONE and DRAIN. bus_wdata and bus_wstrb are 0 when bus_req = 0.
- Maximum one outstanding beat.

Test Plan:
- XLEN=64. LW unsigned=0 at 0x8000_0010; gnt at cycle 2, rvalid at cycle 4 with rdata 0x0000_0000_F000_0001.
  Required: one beat, addr 0x8000_0010, wstrb 0x00; load_data 0xFFFF_FFFF_F000_0001; load_valid in cycle 5; mem_stall high for cycles 0–4.
- LD at 0x8000_0004, SPLIT=1; beat0 rdata 0x1122_3344_xxxx_xxxx, beat1 rdata 0xxxxx_xxxx_5566_7788.
  Required: beats at 0x8000_0000 then 0x8000_0008; load_data 0x5566_7788_1122_3344.
- SH data 0xABCD at 0x8000_0007.
  Required: beat0 wstrb 0x80, wdata[63:56] = 0xCD; beat1 at 0x8000_0008 with wstrb 0x01, wdata[7:0] = 0xAB; store_done pulses once.
- SPLIT=0, LH at 0x8000_0003.
  Required: bus_req never asserts; misalign_exc one-cycle pulse; no load_valid.
- Flush in REQ0 with gnt held low: bus_req falls, IDLE, no pulses. Flush in WAIT0 of a split LD: DRAIN absorbs rvalid, no beat 1 request, no load_valid.
- Assert rst_n=0 mid-WAIT1: outputs 0 and bus_addr = RESET_ADDR immediately (async). A subsequent rvalid after release is ignored.
